uart_core: RTL and testbench

Parametrised full-duplex UART engine: runtime baud divisor, 16x oversampled receiver, configurable data width, parity and stop bits, with valid/ready transmit and valid-pulse receive interfaces. It is the next-generation replacement for the fixed top-level UART and contains its own baud tick generator. It sits between the pad-level `rxd`/`txd` pins and the system-side byte stream logic.

---
 rtl/uart_core.sv | 279 +++++++++++++++++++++++++++
 tb/tb_uart_core.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_core.sv
// Full-duplex UART engine: runtime baud divisor, 16x oversampled receiver,
// configurable data width and parity, one or two stop bits on transmit.
module uart_core #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DVSR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DVSR_WIDTH-1:0] dvsr,
  input  logic [1:0]            parity_mode,
  input  logic                  stop2,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  txd,
  input  logic                  rxd,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  rx_parity_err,
  output logic                  rx_frame_err
);

  localparam int unsigned BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  // Oversample tick generator; >= compare lets a smaller dvsr take effect at once
  logic [DVSR_WIDTH-1:0] tick_cnt_q, tick_cnt_d;
  logic                  tick_c;

  always_comb begin
    tick_c     = (tick_cnt_q >= dvsr);
    tick_cnt_d = tick_c ? '0 : tick_cnt_q + DVSR_WIDTH'(1);
  end

  // ---------------- transmitter ----------------
  logic [2:0]            tx_state_q, tx_state_d;
  logic [4:0]            tx_tick_q, tx_tick_d;
  logic [BIT_W-1:0]      tx_bit_q, tx_bit_d;
  logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic                  tx_pbit_q, tx_pbit_d;
  logic                  tx_pen_q, tx_pen_d;
  logic                  tx_stop2_q, tx_stop2_d;
  logic                  txd_q, txd_d;
  logic                  tx_ready_q, tx_ready_d;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_tick_d  = tx_tick_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_pbit_d  = tx_pbit_q;
    tx_pen_d   = tx_pen_q;
    tx_stop2_d = tx_stop2_q;
    txd_d      = txd_q;
    tx_ready_d = tx_ready_q;
    case (tx_state_q)
      S_IDLE: begin
        if (tx_valid && tx_ready_q) begin
          tx_state_d = S_START;
          tx_tick_d  = '0;
          tx_bit_d   = '0;
          tx_shift_d = tx_data;
          tx_pen_d   = (parity_mode == 2'b01) || (parity_mode == 2'b10);
          tx_pbit_d  = (parity_mode == 2'b10) ? ~^tx_data : ^tx_data;
          tx_stop2_d = stop2;
          txd_d      = 1'b0;
          tx_ready_d = 1'b0;
        end
      end
      S_START: begin
        if (tick_c) begin
          if (tx_tick_q == 5'd15) begin
            tx_state_d = S_DATA;
            tx_tick_d  = '0;
            txd_d      = tx_shift_q[0];
          end else begin
            tx_tick_d = tx_tick_q + 5'd1;
          end
        end
      end
      S_DATA: begin
        if (tick_c) begin
          if (tx_tick_q == 5'd15) begin
            tx_tick_d = '0;
            if (tx_bit_q == BIT_W'(DATA_WIDTH - 1)) begin
              tx_state_d = tx_pen_q ? S_PARITY : S_STOP;
              txd_d      = tx_pen_q ? tx_pbit_q : 1'b1;
            end else begin
              tx_bit_d   = tx_bit_q + BIT_W'(1);
              tx_shift_d = {1'b0, tx_shift_q[DATA_WIDTH-1:1]};
              txd_d      = tx_shift_q[1];
            end
          end else begin
            tx_tick_d = tx_tick_q + 5'd1;
          end
        end
      end
      S_PARITY: begin
        if (tick_c) begin
          if (tx_tick_q == 5'd15) begin
            tx_state_d = S_STOP;
            tx_tick_d  = '0;
            txd_d      = 1'b1;
          end else begin
            tx_tick_d = tx_tick_q + 5'd1;
          end
        end
      end
      S_STOP: begin
        if (tick_c) begin
          if (tx_tick_q == (tx_stop2_q ? 5'd31 : 5'd15)) begin
            tx_state_d = S_IDLE;
            tx_tick_d  = '0;
            txd_d      = 1'b1;
            tx_ready_d = 1'b1;
          end else begin
            tx_tick_d = tx_tick_q + 5'd1;
          end
        end
      end
      default: begin
        tx_state_d = S_IDLE;
        txd_d      = 1'b1;
        tx_ready_d = 1'b1;
      end
    endcase
  end

  // ---------------- receiver ----------------
  logic                  rx_sync1_q, rx_sync2_q;
  logic [2:0]            rx_state_q, rx_state_d;
  logic [3:0]            rx_tick_q, rx_tick_d;
  logic [BIT_W-1:0]      rx_bit_q, rx_bit_d;
  logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic                  rx_perr_q, rx_perr_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  rx_parity_err_q, rx_parity_err_d;
  logic                  rx_frame_err_q, rx_frame_err_d;
  logic                  rx_pen_c, rx_pexp_c;

  always_comb begin
    rx_pen_c        = (parity_mode == 2'b01) || (parity_mode == 2'b10);
    rx_pexp_c       = (parity_mode == 2'b10) ? ~^rx_shift_q : ^rx_shift_q;
    rx_state_d      = rx_state_q;
    rx_tick_d       = rx_tick_q;
    rx_bit_d        = rx_bit_q;
    rx_shift_d      = rx_shift_q;
    rx_perr_d       = rx_perr_q;
    rx_data_d       = rx_data_q;
    rx_valid_d      = 1'b0;
    rx_parity_err_d = rx_parity_err_q;
    rx_frame_err_d  = rx_frame_err_q;
    case (rx_state_q)
      S_IDLE: begin
        if (!rx_sync2_q) begin
          rx_state_d = S_START;
          rx_tick_d  = '0;
        end
      end
      S_START: begin
        // Mid-start-bit check rejects glitches shorter than half a bit
        if (tick_c) begin
          if (rx_tick_q == 4'd7) begin
            rx_tick_d  = '0;
            rx_bit_d   = '0;
            rx_perr_d  = 1'b0;
            rx_state_d = rx_sync2_q ? S_IDLE : S_DATA;
          end else begin
            rx_tick_d = rx_tick_q + 4'd1;
          end
        end
      end
      S_DATA: begin
        if (tick_c) begin
          if (rx_tick_q == 4'd15) begin
            rx_tick_d  = '0;
            rx_shift_d = {rx_sync2_q, rx_shift_q[DATA_WIDTH-1:1]};
            if (rx_bit_q == BIT_W'(DATA_WIDTH - 1)) begin
              rx_state_d = rx_pen_c ? S_PARITY : S_STOP;
            end else begin
              rx_bit_d = rx_bit_q + BIT_W'(1);
            end
          end else begin
            rx_tick_d = rx_tick_q + 4'd1;
          end
        end
      end
      S_PARITY: begin
        if (tick_c) begin
          if (rx_tick_q == 4'd15) begin
            rx_tick_d  = '0;
            rx_perr_d  = (rx_sync2_q != rx_pexp_c);
            rx_state_d = S_STOP;
          end else begin
            rx_tick_d = rx_tick_q + 4'd1;
          end
        end
      end
      S_STOP: begin
        // Deliver at the stop midpoint so a new start bit can follow half a bit later
        if (tick_c) begin
          if (rx_tick_q == 4'd15) begin
            rx_tick_d       = '0;
            rx_data_d       = rx_shift_q;
            rx_parity_err_d = rx_perr_q;
            rx_frame_err_d  = !rx_sync2_q;
            rx_valid_d      = 1'b1;
            rx_state_d      = S_IDLE;
          end else begin
            rx_tick_d = rx_tick_q + 4'd1;
          end
        end
      end
      default: rx_state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt_q      <= '0;
      tx_state_q      <= S_IDLE;
      tx_tick_q       <= '0;
      tx_bit_q        <= '0;
      tx_shift_q      <= '0;
      tx_pbit_q       <= 1'b0;
      tx_pen_q        <= 1'b0;
      tx_stop2_q      <= 1'b0;
      txd_q           <= 1'b1;
      tx_ready_q      <= 1'b1;
      rx_sync1_q      <= 1'b1;
      rx_sync2_q      <= 1'b1;
      rx_state_q      <= S_IDLE;
      rx_tick_q       <= '0;
      rx_bit_q        <= '0;
      rx_shift_q      <= '0;
      rx_perr_q       <= 1'b0;
      rx_data_q       <= '0;
      rx_valid_q      <= 1'b0;
      rx_parity_err_q <= 1'b0;
      rx_frame_err_q  <= 1'b0;
    end else begin
      tick_cnt_q      <= tick_cnt_d;
      tx_state_q      <= tx_state_d;
      tx_tick_q       <= tx_tick_d;
      tx_bit_q        <= tx_bit_d;
      tx_shift_q      <= tx_shift_d;
      tx_pbit_q       <= tx_pbit_d;
      tx_pen_q        <= tx_pen_d;
      tx_stop2_q      <= tx_stop2_d;
      txd_q           <= txd_d;
      tx_ready_q      <= tx_ready_d;
      rx_sync1_q      <= rxd;
      rx_sync2_q      <= rx_sync1_q;
      rx_state_q      <= rx_state_d;
      rx_tick_q       <= rx_tick_d;
      rx_bit_q        <= rx_bit_d;
      rx_shift_q      <= rx_shift_d;
      rx_perr_q       <= rx_perr_d;
      rx_data_q       <= rx_data_d;
      rx_valid_q      <= rx_valid_d;
      rx_parity_err_q <= rx_parity_err_d;
      rx_frame_err_q  <= rx_frame_err_d;
    end
  end

  assign txd           = txd_q;
  assign tx_ready      = tx_ready_q;
  assign rx_data       = rx_data_q;
  assign rx_valid      = rx_valid_q;
  assign rx_parity_err = rx_parity_err_q;
  assign rx_frame_err  = rx_frame_err_q;

endmodule

// File: tb/tb_uart_core.sv
// Self-checking bench for uart_core: directed and randomized frames checked
// against a bit-list frame model and a received-word scoreboard.
module tb_uart_core;

  localparam int unsigned DW = 8;
  localparam int unsigned VW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [VW-1:0] dvsr;
  logic [1:0]    parity_mode;
  logic          stop2;
  logic [DW-1:0] tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic          txd;
  logic          rxd;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic          rx_parity_err;
  logic          rx_frame_err;
  logic          loop;
  logic          rxd_drv;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } rx_item_t;

  rx_item_t rx_q[$];

  always #5 clk = ~clk;

  assign rxd = loop ? txd : rxd_drv;

  uart_core #(.DATA_WIDTH(DW), .DVSR_WIDTH(VW)) dut (
    .clk(clk), .reset(reset), .dvsr(dvsr), .parity_mode(parity_mode),
    .stop2(stop2), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .txd(txd), .rxd(rxd), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_parity_err(rx_parity_err), .rx_frame_err(rx_frame_err)
  );

  always @(negedge clk) if (rx_valid) rx_q.push_back({rx_data, rx_parity_err, rx_frame_err});

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic par_en(input logic [1:0] pm);
    return (pm == 2'b01) || (pm == 2'b10);
  endfunction

  function automatic logic par_bit(input logic [7:0] d, input logic [1:0] pm);
    return (pm == 2'b10) ? ~^d : ^d;
  endfunction

  // Send one word and check the txd waveform against the expected bit list.
  // Called at a negedge; returns at the negedge where tx_ready is seen high again.
  task automatic tx_frame(input logic [7:0] d, input bit keep, output int gap);
    logic exp_bits[$];
    logic q[$];
    logic [15:0] eb, ob;
    int n, nb, dv, blen, len, lo, hi, first, c;
    dv = int'(dvsr);
    blen = 16 * (dv + 1);
    exp_bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_bits.push_back(d[i]);
    if (par_en(parity_mode)) exp_bits.push_back(par_bit(d, parity_mode));
    exp_bits.push_back(1'b1);
    if (stop2) exp_bits.push_back(1'b1);
    nb = exp_bits.size();
    tx_data = d;
    tx_valid = 1'b1;
    n = 0;
    while (!tx_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    gap = n;
    chk("tx_accept", 32'(tx_ready), 32'd1);
    @(posedge clk);
    #1 tx_valid = keep;
    n = 0;
    @(negedge clk);
    while (!tx_ready && n < 20000) begin
      q.push_back(txd);
      n++;
      @(negedge clk);
    end
    len = q.size();
    lo = (16 * nb - 1) * (dv + 1) + 1;
    hi = 16 * nb * (dv + 1);
    chk("tx_len", 32'(len >= lo && len <= hi), 32'd1);
    // All bits after the (possibly short) start bit are exactly one bit period long
    first = len - (16 * nb - 1) * (dv + 1);
    eb = '0;
    ob = '0;
    for (int i = 0; i < nb; i++) begin
      eb[i] = exp_bits[i];
      c = first + (16 * i - 1) * (dv + 1) + blen / 2 - 1;
      ob[i] = (c >= 0 && c < len) ? q[c] : 1'bx;
    end
    chk("tx_bits", 32'(ob), 32'(eb));
    chk("tx_start_imm", 32'((len > 0) ? q[0] : 1'bx), 32'd0);
  endtask

  task automatic line_bit(input logic v, input int cycles);
    rxd_drv = v;
    repeat (cycles) @(negedge clk);
  endtask

  // Bit-bang one frame on rxd; a bad stop bit is held for 3/4 of a bit only
  task automatic rx_drive(input logic [7:0] d, input bit flip, input bit stop_ok);
    int blen;
    blen = 16 * (int'(dvsr) + 1);
    line_bit(1'b0, blen);
    for (int i = 0; i < 8; i++) line_bit(d[i], blen);
    if (par_en(parity_mode)) line_bit(par_bit(d, parity_mode) ^ flip, blen);
    if (stop_ok) line_bit(1'b1, blen);
    else line_bit(1'b0, 12 * (int'(dvsr) + 1));
    rxd_drv = 1'b1;
  endtask

  task automatic rx_expect(input logic [7:0] d, input logic pe, input logic fe, input string tag);
    rx_item_t it;
    int n;
    n = 0;
    while (rx_q.size() == 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_count"}, 32'(rx_q.size()), 32'd1);
    it = 'x;
    if (rx_q.size() != 0) it = rx_q.pop_front();
    chk({tag, "_data"}, 32'(it.d), 32'(d));
    chk({tag, "_perr"}, 32'(it.pe), 32'(pe));
    chk({tag, "_ferr"}, 32'(it.fe), 32'(fe));
    rx_q.delete();
  endtask

  initial begin
    int g, g1, g2, n;
    logic [7:0] d;
    logic flip, stok;
    reset = 1'b1; dvsr = '0; parity_mode = 2'b00; stop2 = 1'b0;
    tx_data = '0; tx_valid = 1'b0; loop = 1'b1; rxd_drv = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_txd", 32'(txd), 32'd1);
    chk("rst_tx_ready", 32'(tx_ready), 32'd1);
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_rx_data", 32'(rx_data), 32'd0);
    chk("rst_perr", 32'(rx_parity_err), 32'd0);
    chk("rst_ferr", 32'(rx_frame_err), 32'd0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // 8N1 loopback at one tick per clock
    tx_frame(8'hA5, 1'b0, g);
    rx_expect(8'hA5, 1'b0, 1'b0, "a5");

    // Even parity, with one and two stop bits
    dvsr = 16'd3; parity_mode = 2'b01;
    tx_frame(8'h07, 1'b0, g);
    rx_expect(8'h07, 1'b0, 1'b0, "even07");
    stop2 = 1'b1;
    tx_frame(8'h07, 1'b0, g);
    rx_expect(8'h07, 1'b0, 1'b0, "even07s2");

    // Randomized loopback frames
    for (int k = 0; k < 12; k++) begin
      repeat ($urandom_range(1, 20)) @(negedge clk);
      dvsr = VW'($urandom_range(0, 3));
      parity_mode = 2'($urandom_range(0, 3));
      stop2 = 1'($urandom_range(0, 1));
      d = 8'($urandom);
      tx_frame(d, 1'b0, g);
      rx_expect(d, 1'b0, 1'b0, "rand_loop");
    end

    // Directed error injection on the receive line
    loop = 1'b0; stop2 = 1'b0;
    dvsr = 16'd1; parity_mode = 2'b10;
    rx_drive(8'h96, 1'b1, 1'b1);
    rx_expect(8'h96, 1'b1, 1'b0, "odd_flip");
    parity_mode = 2'b00;
    rx_drive(8'h3C, 1'b0, 1'b0);
    rx_expect(8'h3C, 1'b0, 1'b1, "ferr3c");
    repeat (64 * 2) @(negedge clk);
    chk("ferr_no_extra", 32'(rx_q.size()), 32'd0);

    // Randomized receive frames with random parity/stop corruption
    for (int k = 0; k < 8; k++) begin
      dvsr = VW'($urandom_range(0, 3));
      parity_mode = 2'($urandom_range(0, 3));
      d = 8'($urandom);
      flip = 1'($urandom_range(0, 1));
      stok = 1'($urandom_range(0, 1));
      rx_drive(d, flip, stok);
      rx_expect(d, flip & par_en(parity_mode), !stok, "rand_rx");
      repeat (40 * (int'(dvsr) + 1)) @(negedge clk);
      chk("rand_rx_no_extra", 32'(rx_q.size()), 32'd0);
    end

    // Start-bit glitch of 4 ticks is rejected
    dvsr = 16'd2; parity_mode = 2'b00;
    line_bit(1'b0, 4 * 3);
    line_bit(1'b1, 40 * 3);
    chk("glitch_no_valid", 32'(rx_q.size()), 32'd0);
    rx_drive(8'h5A, 1'b0, 1'b1);
    rx_expect(8'h5A, 1'b0, 1'b0, "after_glitch");

    // Reset in the middle of a loopback frame
    loop = 1'b1; dvsr = '0; parity_mode = 2'b00; stop2 = 1'b0;
    repeat (20) @(negedge clk);
    tx_data = 8'hC3; tx_valid = 1'b1;
    n = 0;
    while (!tx_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 tx_valid = 1'b0;
    repeat (72) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_txd", 32'(txd), 32'd1);
    chk("mid_rst_tx_ready", 32'(tx_ready), 32'd1);
    chk("mid_rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("mid_rst_rx_data", 32'(rx_data), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (300) @(negedge clk);
    chk("mid_rst_no_rx", 32'(rx_q.size()), 32'd0);
    tx_frame(8'h3D, 1'b0, g);
    rx_expect(8'h3D, 1'b0, 1'b0, "post_rst");

    // Back-to-back transmit while independently receiving
    loop = 1'b0;
    repeat (5) @(negedge clk);
    fork
      begin
        tx_frame(8'h00, 1'b1, g1);
        tx_frame(8'hFF, 1'b0, g2);
        chk("b2b_gap", 32'(g2), 32'd0);
      end
      rx_drive(8'h81, 1'b0, 1'b1);
    join
    rx_expect(8'h81, 1'b0, 1'b0, "duplex81");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
